prefetch_queue: RTL and testbench
=================================

# prefetch_queue

Instruction prefetch queue that sits directly upstream of the execution core's instruction-byte pipeline. It issues byte reads to the synchronous instruction ROM at CS:IP and buffers up to DEPTH returned bytes. It delivers them one per cycle, in program order, to the decoder over a valid/ready handshake. A flush reloads CS:IP for control transfers and discards every buffered and in-flight byte.

## Interface
- DEPTH, 6: queue entries (bytes); legal range 2–8, need not be a power of two
- RESET_CS, 16'h0000: CS value loaded on reset
- RESET_IP, 16'h0000: fetch IP value loaded on reset

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- rom_en  out  1  ROM read strobe; ROM data returns the following cycle
- rom_addr  out  20  physical fetch address
- rom_data  in  8  ROM read data, valid the cycle after rom_en
- flush  in  1  discard queue and restart fetch at flush_cs:flush_ip
- flush_cs  in  16  new code segment, sampled when flush=1
- flush_ip  in  16  new instruction pointer, sampled when flush=1
- out_valid  out  1  head byte available
- out_data  out  8  head byte
- out_ip  out  16  IP of the head byte
- out_ready  in  1  consumer accepts head byte
- level  out  4  bytes currently stored (0..DEPTH)

## Operation
- State registers:
  - cs, fetch_ip: 16 b each
  - pending: 1 b, set when a ROM read is in flight
  - pending_ip: 16 b, IP of the in-flight read
  - queue: DEPTH entries of {byte, ip}
  - rd_ptr, wr_ptr: modulo-DEPTH pointers; wrap from DEPTH-1 to 0 explicitly
  - count
- Physical address rom_addr = ({cs,4'b0} + {4'b0,fetch_ip}) mod 2^20. It is driven combinationally from the registers.
- Issue: rom_en = ~flush && (count + pending < DEPTH), using registered count and pending only. A same-cycle pop does not enable an issue.
  - On issue: fetch_ip <= fetch_ip + 1 (mod 2^16, CS unchanged), pending <= 1, pending_ip <= fetch_ip.
  - Otherwise pending <= 0.
- Return: when pending=1 and flush=0, {rom_data, pending_ip} is written at wr_ptr, and wr_ptr advances.
- Pop: out_valid = (count != 0) && ~flush. Pop occurs when out_valid && out_ready; rd_ptr advances.
- Count update: push only → +1; pop only → −1; push and pop together → unchanged. Overflow is impossible by the issue guard. A push while count==DEPTH is an assertion failure.
- Flush, sampled at the clock edge:
  - count, rd_ptr, wr_ptr, pending <= 0.
  - cs <= flush_cs; fetch_ip <= flush_ip.
  - A ROM return arriving in the flush cycle is dropped.
  - A pop requested in the flush cycle is ignored.
  - Flush has priority over issue, return and pop.
- Back-to-back flushes: only the last one determines the restart address.
- out_data and out_ip come from the head entry. When count==0 their values are don't-care, but stable.
- level = count.

## Timing
- Reset (rst=0, asynchronous):
  - rom_en=0, out_valid=0, level=0, pending=0.
  - cs=RESET_CS, fetch_ip=RESET_IP, so rom_addr = RESET_CS·16 + RESET_IP.
  - The queue contents are cleared to 0.
- After rst deasserts, cycle 0 is the first edge-following cycle:
  - Cycle 0: rom_en=1 at the reset address.
  - Cycle 1: byte returns.
  - Cycle 2: out_valid=1. Fetch-to-output latency is 2 cycles.
- Steady state with out_ready held at 1: one rom_en and one out byte per cycle. level settles at 1 and the pipeline never stalls.
- With out_ready=0: exactly DEPTH reads are issued, then rom_en stays 0 and level=DEPTH. After the first pop, rom_en reasserts the next cycle.
- Flush asserted in cycle t:
  - Cycles t and t+1: rom_en=0 in t; out_valid=0 in t, t+1 and t+2.
  - Cycle t+1: rom_en=1 at flush_cs:flush_ip.
  - Cycle t+3: first new byte is valid.
- Reset asserted mid-stream clears all state immediately. In-flight data is ignored and fetch restarts at the reset address.

## Test plan
- Reset, out_ready=1, ROM returns addr[7:0] → out_data 00,01,02,… from cycle 2 onward; out_ip 0000,0001,…; one byte per cycle, no gaps.
- out_ready=0 after reset → 6 rom_en pulses then silence, level=6. Raise out_ready → bytes 00..05 delivered, then 06.. continues; rom_en resumes one cycle after the first pop.
- Mid-stream flush, CS=16'h1000, IP=16'h0010 → no stale byte ever valid. rom_addr=20'h10010 at t+1; first out_ip=0010 and out_data=10 at t+3.
- IP and address wrap:
  - flush CS=0000, IP=FFFF → rom_addr 0FFFF then 00000; out_ip FFFF then 0000.
  - flush CS=FFFF, IP=0010 → rom_addr 20'h00000.
- Flush coinciding with a ROM return and with out_valid&&out_ready → the returned byte is dropped, the popped byte is not consumed, and level=0 on the next cycle.
- Async rst pulse mid-stream with level=4 → out_valid=0, level=0, rom_en=0 immediately. After release, output restarts at the reset address with 2-cycle latency.

Source files
------------

// File: rtl/prefetch_queue_if.sv
// Fetch-side bundle of the prefetch queue: ROM port,
// flush/redirect, decoder-side byte handshake and fill level.
interface prefetch_queue_if;
    logic        rom_en;
    logic [19:0] rom_addr;
    logic [7:0]  rom_data;
    logic        flush;
    logic [15:0] flush_cs;
    logic [15:0] flush_ip;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [15:0] out_ip;
    logic        out_ready;
    logic [3:0]  level;

    modport master (
        output rom_en, rom_addr,
        output out_valid, out_data, out_ip, level,
        input  rom_data, flush, flush_cs, flush_ip,
        input  out_ready
    );

    modport slave (
        input  rom_en, rom_addr,
        input  out_valid, out_data, out_ip, level,
        output rom_data, flush, flush_cs, flush_ip,
        output out_ready
    );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches bytes at CS:IP from a
// synchronous ROM and hands them to the decoder in order.
module prefetch_queue #(
    parameter int          DEPTH    = 6,
    parameter logic [15:0] RESET_CS = 16'h0000,
    parameter logic [15:0] RESET_IP = 16'h0000
) (
    input logic             clk,
    input logic             rst,
    prefetch_queue_if.master bus
);
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [3:0]    FULL = 4'(DEPTH);

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] ip;
    } entry_t;

    logic [15:0]   cs;
    logic [15:0]   fetch_ip;
    logic [15:0]   pending_ip;
    logic          pending;
    entry_t        q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [3:0]    count;
    logic          issue;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // In-flight read reserves a slot, so the queue can never overflow.
    assign issue = rst && !bus.flush &&
                   (({1'b0, count} + {4'b0, pending}) < {1'b0, FULL});
    assign push  = pending && !bus.flush;
    assign pop   = bus.out_valid && bus.out_ready;

    assign bus.rom_en    = issue;
    assign bus.rom_addr  = {cs, 4'b0} + {4'b0, fetch_ip};
    assign bus.out_valid = (count != 4'd0) && !bus.flush;
    assign bus.out_data  = q[rd_ptr].data;
    assign bus.out_ip    = q[rd_ptr].ip;
    assign bus.level     = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs         <= RESET_CS;
            fetch_ip   <= RESET_IP;
            pending    <= 1'b0;
            pending_ip <= 16'h0000;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= 4'd0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else if (bus.flush) begin
            cs       <= bus.flush_cs;
            fetch_ip <= bus.flush_ip;
            pending  <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= 4'd0;
        end else begin
            pending <= issue;
            if (issue) begin
                fetch_ip   <= fetch_ip + 16'd1;
                pending_ip <= fetch_ip;
            end
            if (push) begin
                q[wr_ptr] <= '{data: bus.rom_data, ip: pending_ip};
                wr_ptr    <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    no_overflow: assert property (
        @(posedge clk) disable iff (!rst)
        !(push && count == FULL)
    );
endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue with a ROM that returns
// the low address byte one cycle after each read strobe.
module tb_prefetch_queue;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   pulses;

    prefetch_queue_if bus ();

    prefetch_queue #(
        .DEPTH    (6),
        .RESET_CS (16'h0000),
        .RESET_IP (16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= bus.rom_addr[7:0];
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [15:0] c,
                            input logic [15:0] i);
        bus.flush    = 1'b1;
        bus.flush_cs = c;
        bus.flush_ip = i;
        #1;
        chk("flush_t_en", 32'(bus.rom_en), 32'd0);
        chk("flush_t_vld", 32'(bus.out_valid), 32'd0);
        tick();
        bus.flush = 1'b0;
        #1;
        chk("flush_t1_en", 32'(bus.rom_en), 32'd1);
        chk("flush_t1_vld", 32'(bus.out_valid), 32'd0);
        chk("flush_t1_lvl", 32'(bus.level), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b0;
        bus.flush     = 1'b0;
        bus.flush_cs  = 16'h0000;
        bus.flush_ip  = 16'h0000;
        bus.out_ready = 1'b1;
        bus.rom_data  = 8'h00;

        // reset state
        tick();
        tick();
        chk("rst_en", 32'(bus.rom_en), 32'd0);
        chk("rst_vld", 32'(bus.out_valid), 32'd0);
        chk("rst_lvl", 32'(bus.level), 32'd0);
        chk("rst_addr", 32'(bus.rom_addr), 32'h00000);

        // streaming with out_ready=1
        rst = 1'b1;
        #1;
        chk("c0_en", 32'(bus.rom_en), 32'd1);
        chk("c0_addr", 32'(bus.rom_addr), 32'h00000);
        chk("c0_vld", 32'(bus.out_valid), 32'd0);
        tick();
        #1;
        chk("c1_vld", 32'(bus.out_valid), 32'd0);
        for (int k = 2; k < 12; k++) begin
            tick();
            #1;
            chk("str_vld", 32'(bus.out_valid), 32'd1);
            chk("str_data", 32'(bus.out_data), 32'(k - 2));
            chk("str_ip", 32'(bus.out_ip), 32'(k - 2));
            chk("str_en", 32'(bus.rom_en), 32'd1);
            chk("str_lvl", 32'(bus.level), 32'd1);
        end

        // backpressure: DEPTH reads then silence
        rst           = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("arst_en", 32'(bus.rom_en), 32'd0);
        chk("arst_vld", 32'(bus.out_valid), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        pulses = 32'(bus.rom_en);
        for (int k = 1; k < 12; k++) begin
            tick();
            #1;
            pulses += 32'(bus.rom_en);
        end
        chk("bp_pulses", pulses, 32'd6);
        chk("bp_lvl", 32'(bus.level), 32'd6);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_pop_en", 32'(bus.rom_en), 32'd0);
        chk("bp_d0", 32'(bus.out_data), 32'h00);
        for (int k = 1; k < 10; k++) begin
            tick();
            #1;
            if (k == 1) chk("bp_resume", 32'(bus.rom_en), 32'd1);
            chk("bp_vld", 32'(bus.out_valid), 32'd1);
            chk("bp_data", 32'(bus.out_data), 32'(k));
        end

        // mid-stream flush to 1000:0010
        tick();
        do_flush(16'h1000, 16'h0010);
        chk("f1_addr", 32'(bus.rom_addr), 32'h10010);
        tick();
        #1;
        chk("f1_t2_vld", 32'(bus.out_valid), 32'd0);
        tick();
        #1;
        chk("f1_t3_vld", 32'(bus.out_valid), 32'd1);
        chk("f1_t3_ip", 32'(bus.out_ip), 32'h0010);
        chk("f1_t3_data", 32'(bus.out_data), 32'h10);
        tick();
        #1;
        chk("f1_t4_ip", 32'(bus.out_ip), 32'h0011);
        chk("f1_t4_data", 32'(bus.out_data), 32'h11);

        // IP wrap at 0000:FFFF
        tick();
        do_flush(16'h0000, 16'hFFFF);
        chk("w1_addr", 32'(bus.rom_addr), 32'h0FFFF);
        tick();
        #1;
        chk("w1_addr2", 32'(bus.rom_addr), 32'h00000);
        tick();
        #1;
        chk("w1_ip0", 32'(bus.out_ip), 32'hFFFF);
        chk("w1_d0", 32'(bus.out_data), 32'hFF);
        tick();
        #1;
        chk("w1_ip1", 32'(bus.out_ip), 32'h0000);
        chk("w1_d1", 32'(bus.out_data), 32'h00);

        // physical address wrap at FFFF:0010
        tick();
        do_flush(16'hFFFF, 16'h0010);
        chk("w2_addr", 32'(bus.rom_addr), 32'h00000);
        tick();
        tick();
        #1;
        chk("w2_ip", 32'(bus.out_ip), 32'h0010);
        chk("w2_data", 32'(bus.out_data), 32'h00);

        // flush with a return in flight and a pop pending
        tick();
        tick();
        chk("fx_pre_vld", 32'(bus.out_valid), 32'd1);
        chk("fx_pre_lvl", 32'(bus.level), 32'd1);
        do_flush(16'h0000, 16'h0040);
        chk("fx_addr", 32'(bus.rom_addr), 32'h00040);
        tick();
        #1;
        chk("fx_t2_vld", 32'(bus.out_valid), 32'd0);
        chk("fx_t2_lvl", 32'(bus.level), 32'd0);
        tick();
        #1;
        chk("fx_t3_ip", 32'(bus.out_ip), 32'h0040);
        chk("fx_t3_data", 32'(bus.out_data), 32'h40);

        // async reset pulse with level=4
        rst           = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        #1;
        chk("ar_pre_lvl", 32'(bus.level), 32'd4);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_vld", 32'(bus.out_valid), 32'd0);
        chk("ar_lvl", 32'(bus.level), 32'd0);
        chk("ar_en", 32'(bus.rom_en), 32'd0);
        tick();
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("ar_c0_en", 32'(bus.rom_en), 32'd1);
        chk("ar_c0_addr", 32'(bus.rom_addr), 32'h00000);
        tick();
        #1;
        chk("ar_c1_vld", 32'(bus.out_valid), 32'd0);
        tick();
        #1;
        chk("ar_c2_vld", 32'(bus.out_valid), 32'd1);
        chk("ar_c2_data", 32'(bus.out_data), 32'h00);
        chk("ar_c2_ip", 32'(bus.out_ip), 32'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
